// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit seven-segment scan controller.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [3:0] AN_RESET  = 4'b0001;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Map each hex value onto its gfedcba pattern.
  always_comb begin
    seg = SEG_HEX_0;
    case (nibble)
      4'h0: seg = SEG_HEX_0;
      4'h1: seg = SEG_HEX_1;
      4'h2: seg = SEG_HEX_2;
      4'h3: seg = SEG_HEX_3;
      4'h4: seg = SEG_HEX_4;
      4'h5: seg = SEG_HEX_5;
      4'h6: seg = SEG_HEX_6;
      4'h7: seg = SEG_HEX_7;
      4'h8: seg = SEG_HEX_8;
      4'h9: seg = SEG_HEX_9;
      4'hA: seg = SEG_HEX_A;
      4'hB: seg = SEG_HEX_B;
      4'hC: seg = SEG_HEX_C;
      4'hD: seg = SEG_HEX_D;
      4'hE: seg = SEG_HEX_E;
      4'hF: seg = SEG_HEX_F;
      default: seg = SEG_HEX_0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment scan controller.
// New values are held in a shadow register and adopted only at a frame
// boundary, so one frame never mixes old and new digits.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 is always shown).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_DIV = 50000,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] value_in,
  input  logic        load,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        pending,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic             resume;
  logic [15:0]      shadow;
  logic [15:0]      display;

  logic             tick;
  logic             frame_start;
  logic             wrap;
  logic [1:0]       next_idx;
  logic [15:0]      next_disp;
  logic [3:0]       nibble;
  logic [6:0]       dec_seg;
  logic [6:0]       next_seg;

  // Work out the slot being entered on this tick and the value it displays,
  // so seg is registered together with the anode it belongs to.
  always_comb begin
    tick        = enable && (cnt == CNT_MAX);
    frame_start = tick && (idx == 2'd3);
    wrap        = frame_start && !resume;
    next_idx    = idx + 2'd1;
    next_disp   = display;
    if (frame_start) begin
      if (load) begin
        next_disp = value_in;
      end else if (pending) begin
        next_disp = shadow;
      end
    end
    nibble = next_disp[3:0];
    case (next_idx)
      2'd0: nibble = next_disp[3:0];
      2'd1: nibble = next_disp[7:4];
      2'd2: nibble = next_disp[11:8];
      2'd3: nibble = next_disp[15:12];
      default: nibble = next_disp[3:0];
    endcase
  end

  seg7_hex_decode u_decode (
    .nibble (nibble),
    .seg    (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Blank a digit when it and every more significant digit are zero.
  always_comb begin
    next_seg = dec_seg;
    case (next_idx)
      2'd3: if (next_disp[15:12] == 4'h0) next_seg = SEG_BLANK;
      2'd2: if (next_disp[15:8] == 8'h00) next_seg = SEG_BLANK;
      2'd1: if (next_disp[15:4] == 12'h000) next_seg = SEG_BLANK;
      default: next_seg = dec_seg;
    endcase
  end
`else
  // Every digit is always decoded.
  always_comb begin
    next_seg = dec_seg;
  end
`endif

  // Prescaler, anode rotation, shadow/display handoff and blanking state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 2'd0;
      resume     <= 1'b0;
      an         <= AN_RESET;
      seg        <= SEG_HEX_0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      shadow     <= 16'h0000;
      display    <= 16'h0000;
    end else if (!enable) begin
      cnt        <= '0;
      idx        <= 2'd3;
      resume     <= 1'b1;
      an         <= '0;
      seg        <= SEG_BLANK;
      frame_done <= 1'b0;
      if (load) begin
        shadow  <= value_in;
        pending <= 1'b1;
      end else if (pending) begin
        display <= shadow;
        pending <= 1'b0;
      end
    end else begin
      frame_done <= wrap;
      if (load) begin
        shadow <= value_in;
      end
      if (tick) begin
        cnt    <= '0;
        idx    <= next_idx;
        resume <= 1'b0;
        an     <= AN_RESET << next_idx;
        seg    <= next_seg;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (frame_start) begin
        display <= next_disp;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
